// File: rtl/instr_stream_driver_pkg.sv
// Shared constants for the instruction-stream driver: idle instruction,
// FSM state encoding and a few RISC-V opcodes used by stimulus code.
package instr_stream_driver_pkg;

    localparam logic [31:0] NOP_INSN_C = 32'h0000_0013;  // ADDI x0,x0,0

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

endpackage

// File: rtl/instr_stream_driver_prog_mem.sv
// Program store: DEPTH x XLEN registers, one synchronous write port,
// one combinational read port, async reset of every entry to RST_VAL.
module instr_prog_mem #(
    parameter int              XLEN    = 32,
    parameter int              DEPTH   = 16,
    parameter int              ADDR_W  = 4,
    parameter logic [XLEN-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [XLEN-1:0]   rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_stream_driver.sv
// Plays a loaded program into the core's IR port over valid/ready, with
// optional looping, inter-instruction gaps, abort, and issue/stall counters.
module instr_stream_driver
    import instr_stream_driver_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 16,
    parameter int              ADDR_W   = 4,
    parameter int              GAP_W    = 4,
    parameter int              CNT_W    = 16,
    parameter logic [XLEN-1:0] NOP_INSN = XLEN'(NOP_INSN_C)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [XLEN-1:0]   load_data,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_mode,
    input  logic [ADDR_W:0]   prog_len,
    input  logic [GAP_W-1:0]  gap_cycles,
    output logic [XLEN-1:0]   ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issued_count,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [GAP_W-1:0]  gap_q;
    logic [ADDR_W:0]   len_q;
    logic              loop_q;
    logic [GAP_W-1:0]  gapcfg_q;
    logic [XLEN-1:0]   ir_out_q;
    logic              ir_valid_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  stall_q;

    logic              mem_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;
    logic              last;
    logic [ADDR_W-1:0] pc_nxt;
    logic              hshake;
    logic [ADDR_W:0]   len_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mem_we = load_en && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last   = (({1'b0, pc_q} + (ADDR_W+1)'(1)) == len_q);
    assign pc_nxt = last ? '0 : pc_q + ADDR_W'(1);
    assign hshake = ir_valid_q && ir_ready;
    assign len_d  = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

    // Read address anticipates the word that gets registered into ir_out.
    always_comb begin
        rd_addr = '0;
        if (state_q == ST_ISSUE)    rd_addr = pc_nxt;
        else if (state_q == ST_GAP) rd_addr = pc_q;
    end

    instr_prog_mem #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RST_VAL(NOP_INSN)
    ) u_mem (
        .clk_i  (clk),
        .rst_i  (reset),
        .we_i   (mem_we),
        .waddr_i(load_addr),
        .wdata_i(load_data),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            gap_q      <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            gapcfg_q   <= '0;
            ir_out_q   <= NOP_INSN;
            ir_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            issued_q   <= '0;
            stall_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start && !(abort && state_q == ST_IDLE)) begin
                        len_q    <= len_d;
                        loop_q   <= loop_mode;
                        gapcfg_q <= gap_cycles;
                        issued_q <= '0;
                        stall_q  <= '0;
                        pc_q     <= '0;
                        if (len_d == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_ISSUE;
                            ir_out_q   <= rd_data;
                            ir_valid_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!ir_ready) stall_q  <= sat_inc(stall_q);
                    if (hshake)    issued_q <= sat_inc(issued_q);
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        ir_out_q   <= NOP_INSN;
                        ir_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                    end else if (hshake) begin
                        if (last && !loop_q) begin
                            state_q    <= ST_DONE;
                            ir_out_q   <= NOP_INSN;
                            ir_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            pc_q <= pc_nxt;
                            if (gapcfg_q == '0) begin
                                ir_out_q <= rd_data;
                            end else begin
                                state_q    <= ST_GAP;
                                gap_q      <= gapcfg_q;
                                ir_out_q   <= NOP_INSN;
                                ir_valid_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                        gap_q    <= '0;
                    end else if (gap_q == GAP_W'(1)) begin
                        state_q    <= ST_ISSUE;
                        gap_q      <= '0;
                        ir_out_q   <= rd_data;
                        ir_valid_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ir_out       = ir_out_q;
    assign ir_valid     = ir_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign issued_count = issued_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_instr_stream_driver.sv
// Directed bench for instr_stream_driver: hand-computed expectations for
// one-shot, backpressure, gaps, loop/abort, edge lengths, load-while-busy, reset.
module tb_instr_stream_driver;

    localparam int ADDR_W = 4;
    localparam int GAP_W  = 4;
    localparam int CNT_W  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              start;
    logic              abort;
    logic              loop_mode;
    logic [ADDR_W:0]   prog_len;
    logic [GAP_W-1:0]  gap_cycles;
    logic [31:0]       ir_out;
    logic              ir_valid;
    logic              ir_ready;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  issued_count;
    logic [CNT_W-1:0]  stall_count;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] prog [4];

    instr_stream_driver dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .abort       (abort),
        .loop_mode   (loop_mode),
        .prog_len    (prog_len),
        .gap_cycles  (gap_cycles),
        .ir_out      (ir_out),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .busy        (busy),
        .done        (done),
        .issued_count(issued_count),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = ADDR_W'(a);
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        prog[0] = 32'h0020_0093;
        prog[1] = 32'h0010_2223;
        prog[2] = 32'h0040_2103;
        prog[3] = 32'h0020_81B3;

        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; abort = 1'b0; loop_mode = 1'b0; prog_len = '0;
        gap_cycles = '0; ir_ready = 1'b1;
        tick(); tick();
        chk("rst_ir_out", ir_out, NOP);
        chk("rst_valid", {31'b0, ir_valid}, 0);
        chk("rst_busy_done", {30'b0, busy, done}, 0);
        chk("rst_issued", {16'b0, issued_count}, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) load(i, prog[i]);

        // one-shot back-to-back
        prog_len = 5'd4; gap_cycles = '0; loop_mode = 1'b0;
        go();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_word%0d", i), ir_out, prog[i]);
            chk($sformatf("b2b_valid%0d", i), {31'b0, ir_valid}, 1);
            tick();
        end
        chk("b2b_done", {31'b0, done}, 1);
        chk("b2b_valid_off", {31'b0, ir_valid}, 0);
        chk("b2b_ir_nop", ir_out, NOP);
        chk("b2b_issued", {16'b0, issued_count}, 4);
        chk("b2b_stall", {16'b0, stall_count}, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("done_abort_ignored", {31'b0, done}, 1);

        // backpressure on entry 1
        go();
        chk("bp_word0", ir_out, prog[0]);
        tick();
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold%0d", i), ir_out, prog[1]);
            tick();
        end
        chk("bp_hold3", ir_out, prog[1]);
        chk("bp_stall", {16'b0, stall_count}, 3);
        ir_ready = 1'b1;
        tick();
        chk("bp_word2", ir_out, prog[2]);
        tick();
        chk("bp_word3", ir_out, prog[3]);
        chk("bp_not_done", {31'b0, done}, 0);
        tick();
        chk("bp_done", {31'b0, done}, 1);
        chk("bp_issued", {16'b0, issued_count}, 4);

        // gap insertion
        prog_len = 5'd2; gap_cycles = 4'd2;
        go();
        chk("gap_v0", {31'b0, ir_valid}, 1);
        chk("gap_w0", ir_out, prog[0]);
        gap_cycles = 4'd0;  // must not affect the running playback
        tick();
        chk("gap_v1", {31'b0, ir_valid}, 0);
        chk("gap_nop1", ir_out, NOP);
        chk("gap_busy", {31'b0, busy}, 1);
        tick();
        chk("gap_v2", {31'b0, ir_valid}, 0);
        chk("gap_nop2", ir_out, NOP);
        tick();
        chk("gap_v3", {31'b0, ir_valid}, 1);
        chk("gap_w1", ir_out, prog[1]);
        tick();
        chk("gap_done", {31'b0, done}, 1);
        chk("gap_issued", {16'b0, issued_count}, 2);

        // loop + abort with handshake in the abort cycle
        prog_len = 5'd3; loop_mode = 1'b1; gap_cycles = '0;
        go();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("loop_w%0d", i), ir_out, prog[i % 3]);
            if (i == 6) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("loop_valid_off", {31'b0, ir_valid}, 0);
        chk("loop_ir_nop", ir_out, NOP);
        chk("loop_busy_done", {30'b0, busy, done}, 0);
        chk("loop_issued", {16'b0, issued_count}, 7);
        tick();
        chk("loop_issued_hold", {16'b0, issued_count}, 7);

        // abort + start in IDLE: stays idle
        loop_mode = 1'b0; prog_len = 5'd4;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", {31'b0, busy}, 0);
        chk("abort_start_valid", {31'b0, ir_valid}, 0);

        // prog_len = 0
        prog_len = 5'd0;
        go();
        chk("len0_done", {31'b0, done}, 1);
        chk("len0_valid", {31'b0, ir_valid}, 0);
        chk("len0_issued", {16'b0, issued_count}, 0);

        // clamp prog_len 20 -> 16
        for (int i = 0; i < 16; i++) load(i, 32'h1000_0000 + 32'(i));
        prog_len = 5'd20;
        go();
        prog_len = 5'd2;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("clamp_w%0d", i), ir_out, 32'h1000_0000 + 32'(i));
            tick();
        end
        chk("clamp_done", {31'b0, done}, 1);
        chk("clamp_issued", {16'b0, issued_count}, 16);

        // load while busy is ignored
        prog_len = 5'd16; ir_ready = 1'b0;
        go();
        load(5, 32'hDEAD_BEEF);
        chk("lwb_busy", {31'b0, busy}, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        ir_ready = 1'b1;
        go();
        repeat (5) tick();
        chk("lwb_mem5", ir_out, 32'h1000_0005);

        // async reset mid-issue
        reset = 1'b1;
        #2;
        chk("mrst_ir_out", ir_out, NOP);
        chk("mrst_flags", {29'b0, ir_valid, busy, done}, 0);
        chk("mrst_issued", {16'b0, issued_count}, 0);
        chk("mrst_stall", {16'b0, stall_count}, 0);
        tick();
        reset = 1'b0;
        prog_len = 5'd4;
        go();
        chk("mrst_mem0_nop", ir_out, NOP);
        chk("mrst_valid", {31'b0, ir_valid}, 1);
        tick();
        chk("mrst_mem1_nop", ir_out, NOP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
